// File: rtl/img_pkg.sv
// Shared constants for the image pipeline (source -> FIFO -> sobel -> FIFO -> sink).
//   PIX_W  : pixel width in bits
//   IMG_W  : image width in pixels
//   IMG_H  : image height in lines
//   clog2  : ceil(log2(n)) for use in parameter and port-width expressions
package img_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned IMG_W = 720;
    localparam int unsigned IMG_H = 540;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for fwft_fifo.
//   clock : write clock
//   we    : write enable, wdata stored at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address (the FIFO read pointer)
//   rdata : word at raddr; it is captured by the FIFO head register, which
//           acts as this RAM's registered read stage
module fifo_ram #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned WORDS  = 15,
    parameter int unsigned AW     = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO, single clock.
// Storage is a (DEPTH-1)-word RAM plus a head register that drives dout, so
// total capacity is DEPTH. dout is valid whenever empty=0; a pop (rd_en with
// empty=0) consumes the head in the same cycle.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   wr_en, din, full    : write side; write accepted when wr_en & ~full
//   almost_full         : count >= AF_LEVEL
//   rd_en, dout, empty  : read side; pop accepted when rd_en & ~empty
//   count               : words held, 0..DEPTH
//   overflow, underflow : sticky, write-while-full / read-while-empty seen
// All outputs are registered.
module fwft_fifo
    import img_pkg::*;
#(
    parameter int unsigned DWIDTH   = PIX_W,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DWIDTH-1:0]     din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DWIDTH-1:0]     dout,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned RAM_WORDS = DEPTH - 1;
    localparam int unsigned AW        = clog2(RAM_WORDS);
    localparam int unsigned CW        = clog2(DEPTH) + 1;

    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DWIDTH-1:0] head_q, head_d;
    logic              full_q, empty_q, af_q, ovf_q, unf_q;

    logic              wr_acc, rd_acc, last_one, ram_we;
    logic [DWIDTH-1:0] ram_rdata;

    // RAM pointers wrap modulo DEPTH-1, which need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(RAM_WORDS - 1)) ? '0 : p + 1'b1;
    endfunction

    fifo_ram #(
        .DWIDTH (DWIDTH),
        .WORDS  (RAM_WORDS),
        .AW     (AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign wr_acc   = wr_en & ~full_q;
    assign rd_acc   = rd_en & ~empty_q;
    assign last_one = (count_q == CW'(1));

    always_comb begin
        head_d   = head_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ram_we   = 1'b0;
        count_d  = count_q;

        if (wr_acc && (empty_q || (rd_acc && last_one))) begin
            // Head is (or becomes) vacant with the RAM empty: din bypasses.
            head_d = din;
        end else begin
            // RAM holds count-1 words, so with count>=2 its read word is next.
            if (rd_acc && !last_one) begin
                head_d   = ram_rdata;
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (wr_acc) begin
                ram_we   = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            af_q     <= (count_d >= CW'(AF_LEVEL));
            ovf_q    <= ovf_q | (wr_en & full_q);
            unf_q    <= unf_q | (rd_en & empty_q);
        end
    end

    assign full        = full_q;
    assign almost_full = af_q;
    assign dout        = head_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_fwft_fifo.sv
// Self-checking bench for fwft_fifo (DWIDTH=8, DEPTH=16, AF_LEVEL=14).
// A reference queue models the FIFO; every pop is compared with the queue head
// and after every edge count/flags/head are compared with the model.
module tb_fwft_fifo;

    localparam int DEPTH = 16;
    localparam int AFL   = 14;

    logic       clock, reset, wr_en, rd_en;
    logic [7:0] din, dout;
    logic       full, almost_full, empty, overflow, underflow;
    logic [4:0] count;

    int         vectors, miscompares;
    logic [7:0] sb [$];
    logic       m_ovf, m_unf;

    fwft_fifo dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .din         (din),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .dout        (dout),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic wa, ra;
        wr_en = w;
        rd_en = r;
        din   = d;
        wa = w && (sb.size() < DEPTH);
        ra = r && (sb.size() > 0);
        if (ra) chk("pop_data", dout, sb[0]);
        if (w && sb.size() == DEPTH) m_ovf = 1'b1;
        if (r && sb.size() == 0) m_unf = 1'b1;
        @(posedge clock);
        #1;
        if (ra) void'(sb.pop_front());
        if (wa) sb.push_back(d);
        chk("count", count, sb.size());
        chk("empty", empty, sb.size() == 0);
        chk("full", full, sb.size() == DEPTH);
        chk("almost_full", almost_full, sb.size() >= AFL);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
        if (sb.size() > 0) chk("head", dout, sb[0]);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  din;
        int unsigned cnt;
        logic        emp;
        logic        dchk;
        logic [7:0]  dout;
    } vec_t;

    vec_t tbl [8];
    logic [7:0] d;

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;

        // Hand-derived single-word and short-sequence vectors.
        tbl[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b1, 8'h11};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b1, 8'h11};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 8'h22, 1, 1'b0, 1'b1, 8'h22};
        tbl[4] = '{1'b1, 1'b0, 8'h33, 2, 1'b0, 1'b1, 8'h22};
        tbl[5] = '{1'b1, 1'b1, 8'h44, 2, 1'b0, 1'b1, 8'h33};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 8'h44};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00};

        #12;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_af", almost_full, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_unf", underflow, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk("tbl_count", count, tbl[i].cnt);
            chk("tbl_empty", empty, tbl[i].emp);
            if (tbl[i].dchk) chk("tbl_dout", dout, tbl[i].dout);
        end

        // Fill 0x00..0x0F, then an ignored write while full, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk("fill_af", almost_full, (i + 1) >= AFL);
        end
        chk("fill_full", full, 1'b1);
        step(1'b1, 1'b0, 8'hFF);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", count, 16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", dout, 8'(i));
            step(1'b0, 1'b1, 8'h00);
        end
        chk("drain_empty", empty, 1'b1);

        // Steady state at count=5 with simultaneous read/write; wraps pointers.
        d = 8'h40;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, d);
            d++;
        end
        for (int i = 0; i < 40; i++) begin
            chk("stream_dout", dout, d - 8'd5);
            step(1'b1, 1'b1, d);
            d++;
            chk("stream_count", count, 5);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);

        // Read+write into an empty FIFO: read ignored, write lands in head.
        step(1'b1, 1'b1, 8'hA5);
        chk("unf_set", underflow, 1'b1);
        chk("unf_count", count, 1);
        chk("unf_dout", dout, 8'hA5);

        // Asynchronous reset in the middle of a cycle with 9 words held.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_empty", empty, 1'b1);
        chk("arst_count", count, 0);
        chk("arst_full", full, 1'b0);
        chk("arst_dout", dout, 8'h00);
        chk("arst_unf", underflow, 1'b0);
        chk("arst_ovf", overflow, 1'b0);
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;

        // Fresh fill, then read+write while full: write must be dropped.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
        chk("full2", full, 1'b1);
        chk("full2_ovf", overflow, 1'b0);
        step(1'b1, 1'b1, 8'h77);
        chk("rw_full_count", count, 15);
        chk("rw_full_ovf", overflow, 1'b1);
        chk("rw_full_head", dout, 8'h81);
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (dout === 8'h77) chk("no_77", dout, 8'h81 + 8'(i));
            step(1'b0, 1'b1, 8'h00);
        end
        chk("end_empty", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
